// File: rtl/ps2_pkg.sv
// ps2_pkg: frame layout constants and the parity helper for the PS/2 receiver.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;
  localparam int START_IDX      = 0;
  localparam int PARITY_IDX     = 9;
  localparam int STOP_IDX       = 10;

  // Odd parity: data plus parity bit must carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo: single-clock FIFO for received scan codes.
// Ports:
//   clk, resetn   clock and synchronous active-low reset
//   i_push        write request; accepted when not full, or when full with a pop
//   i_wdata       data to write
//   i_pop         read request; ignored while empty
//   o_full        registered full flag
//   o_empty       registered empty flag
//   o_rdata       entry at the read pointer (combinational from storage)
module ps2_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             r_full;
  logic             r_empty;

  logic             w_pop_ok;
  logic             w_push_ok;
  logic [AW:0]      w_wptr_nxt;
  logic [AW:0]      w_rptr_nxt;

  // A pop frees the slot being written, so a full FIFO still accepts a push paired with a pop.
  assign w_pop_ok   = i_pop & ~r_empty;
  assign w_push_ok  = i_push & (~r_full | w_pop_ok);
  assign w_wptr_nxt = r_wptr + (AW+1)'(w_push_ok);
  assign w_rptr_nxt = r_rptr + (AW+1)'(w_pop_ok);

  // Pointers and flags; the extra pointer MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= {(AW+1){1'b0}};
      r_rptr  <= {(AW+1){1'b0}};
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_empty <= (w_wptr_nxt == w_rptr_nxt);
      r_full  <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                 (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
    end
  end

  // Storage: cleared on reset, written at the write pointer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_push_ok) begin
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end else begin
      r_mem <= r_mem;
    end
  end

  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver (device-to-host only). Synchronises the raw
// pins, detects ps2_clk falling edges, assembles 11-bit frames, validates them and
// queues good scan codes in ps2_sync_fifo.
// Ports:
//   clk, resetn   system clock, synchronous active-low reset
//   ps2_clk       raw PS/2 clock (asynchronous)
//   ps2_data      raw PS/2 data (asynchronous)
//   nextdata_n    active-low pop strobe
//   data          scan code at FIFO head (valid while ready=1)
//   ready         FIFO not empty
//   overflow      sticky: valid frame arrived while FIFO full and not popping
//   frame_err     one-cycle pulse for a rejected frame
// Build option: define PS2_KBD_RX_PARITY_CHECK_EN to reject frames with bad odd
// parity; otherwise only start and stop bits are checked.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     nextdata_n,
  output logic [PS2_DATA_BITS-1:0] data,
  output logic                     ready,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    LAST_BIT = 4'(STOP_IDX);

  logic [SYNC_STAGES-1:0]    r_clk_sync;
  logic [SYNC_STAGES-1:0]    r_dat_sync;
  logic [3:0]                r_bit_cnt;
  logic [PS2_FRAME_BITS-2:0] r_shift;
  logic [TW-1:0]             r_to_cnt;
  logic                      r_overflow;
  logic                      r_frame_err;

  logic                      w_fall;
  logic                      w_bit;
  logic                      w_last;
  logic [PS2_FRAME_BITS-1:0] w_frame;
  logic                      w_parity_ok;
  logic                      w_frame_ok;
  logic                      w_push_req;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [PS2_DATA_BITS-1:0]  w_rdata;

  // Pin synchronisers; reset to the idle-high line level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_clk_sync <= {SYNC_STAGES{1'b1}};
      r_dat_sync <= {SYNC_STAGES{1'b1}};
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Oldest sample 1, next-oldest 0: ps2_clk fell.
  assign w_fall = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
  assign w_bit  = r_dat_sync[SYNC_STAGES-1];
  assign w_last = (r_bit_cnt == LAST_BIT);

  // Bits 0..9 live in r_shift; the stop bit is taken straight from the pin on the last edge.
  assign w_frame = {w_bit, r_shift};

  assign w_parity_ok = odd_parity_ok(w_frame[PARITY_IDX-1:START_IDX+1], w_frame[PARITY_IDX]);
`ifdef PS2_KBD_RX_PARITY_CHECK_EN
  assign w_frame_ok = ~w_frame[START_IDX] & w_frame[STOP_IDX] & w_parity_ok;
`else
  // Parity is still captured and computed but does not gate acceptance.
  assign w_frame_ok = ~w_frame[START_IDX] & w_frame[STOP_IDX] & (w_parity_ok | 1'b1);
`endif

  assign w_push_req = w_fall & w_last & w_frame_ok;
  assign w_pop      = ~nextdata_n & ~w_empty;

  // Bit counter, shift register and idle timeout for partial frames.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= {(PS2_FRAME_BITS-1){1'b0}};
      r_to_cnt  <= {TW{1'b0}};
    end else if (w_fall) begin
      r_to_cnt  <= {TW{1'b0}};
      r_shift   <= {w_bit, r_shift[PS2_FRAME_BITS-2:1]};
      r_bit_cnt <= w_last ? 4'd0 : r_bit_cnt + 4'd1;
    end else if (r_bit_cnt != 4'd0) begin
      if (r_to_cnt == TO_LIMIT) begin
        r_bit_cnt <= 4'd0;
        r_to_cnt  <= {TW{1'b0}};
      end else begin
        r_to_cnt  <= r_to_cnt + {{(TW-1){1'b0}}, 1'b1};
      end
    end else begin
      r_to_cnt <= {TW{1'b0}};
    end
  end

  // Status outputs: error pulse and sticky overflow (a same-cycle pop makes room).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_fall & w_last & ~w_frame_ok;
      r_overflow  <= r_overflow | (w_push_req & w_full & ~w_pop);
    end
  end

  ps2_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push_req),
    .i_wdata (w_frame[PARITY_IDX-1:START_IDX+1]),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_rdata (w_rdata)
  );

  assign data      = w_rdata;
  assign ready     = ~w_empty;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed bench for ps2_kbd_rx. A queue-based model of the
// receiver is updated as frames and pops are driven; one compare process checks
// the DUT against it on every settled cycle and also evaluates literal pins.
module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;
  localparam int SYNC  = 3;
  localparam int TO    = 300;
  localparam int H     = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  ps2_kbd_rx #(
    .FIFO_DEPTH     (DEPTH),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Model state (written by the stimulus process only)
  logic [7:0] q[$];
  logic       ovf_exp = 1'b0;
  int         err_exp = 0;
  bit         chk_en = 1'b0;

  // Literal pin requests
  int         pin_seq = 0;
  string      pin_name;
  logic       pin_ready;
  bit         pin_dchk;
  logic [7:0] pin_data;
  logic       pin_ovf;
  int         pin_err;

  // Counters (written by the compare process only)
  int n_checks = 0;
  int n_fail = 0;
  int pin_done = 0;
  int err_cycles = 0;
  int err_rises = 0;
  logic err_prev = 1'b0;

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cycles++;
    if (frame_err === 1'b1 && err_prev !== 1'b1) err_rises++;
    err_prev = frame_err;
    if (chk_en) begin
      n_checks++;
      if (ready !== (q.size() != 0)) begin
        n_fail++; $display("FAIL model_ready: got %b expected %b", ready, q.size() != 0);
      end
      if (q.size() != 0) begin
        n_checks++;
        if (data !== q[0]) begin
          n_fail++; $display("FAIL model_data: got %h expected %h", data, q[0]);
        end
      end
      n_checks++;
      if (overflow !== ovf_exp) begin
        n_fail++; $display("FAIL model_overflow: got %b expected %b", overflow, ovf_exp);
      end
      n_checks++;
      if (err_rises != err_exp || err_cycles != err_exp) begin
        n_fail++;
        $display("FAIL model_frame_err: got %0d pulses/%0d cycles expected %0d", err_rises, err_cycles, err_exp);
      end
    end
    if (pin_seq != pin_done) begin
      pin_done = pin_seq;
      n_checks++;
      if (ready !== pin_ready) begin
        n_fail++; $display("FAIL %s ready: got %b expected %b", pin_name, ready, pin_ready);
      end
      if (pin_dchk) begin
        n_checks++;
        if (data !== pin_data) begin
          n_fail++; $display("FAIL %s data: got %h expected %h", pin_name, data, pin_data);
        end
      end
      n_checks++;
      if (overflow !== pin_ovf) begin
        n_fail++; $display("FAIL %s overflow: got %b expected %b", pin_name, overflow, pin_ovf);
      end
      if (pin_err >= 0) begin
        n_checks++;
        if (err_rises != pin_err || frame_err !== 1'b0) begin
          n_fail++; $display("FAIL %s frame_err: got %0d pulses (now %b) expected %0d", pin_name, err_rises, frame_err, pin_err);
        end
      end
    end
  end

  task automatic post_pin(input string nm, input logic rdy, input bit dchk, input logic [7:0] d,
                          input logic ov, input int e);
    pin_name = nm; pin_ready = rdy; pin_dchk = dchk; pin_data = d; pin_ovf = ov; pin_err = e;
    pin_seq++;
  endtask

  task automatic pin(input string nm, input logic rdy, input bit dchk, input logic [7:0] d,
                     input logic ov, input int e);
    post_pin(nm, rdy, dchk, d, ov, e);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk); ps2_data = b;
    repeat (H) @(negedge clk); ps2_clk = 1'b0;
    repeat (H) @(negedge clk); ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic par_flip, input logic stop_v);
    return {stop_v, (~^code) ^ par_flip, code, 1'b0};
  endfunction

  task automatic send_partial(input logic [7:0] code, input int n);
    logic [10:0] f;
    f = mk_frame(code, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) send_bit(f[i]);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par_flip, input logic stop_v,
                            input bit pin_lat, input bit pop_at_stop);
    logic [10:0] f;
    bit          ok;
    f = mk_frame(code, par_flip, stop_v);
    chk_en = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    @(negedge clk); ps2_data = f[10];
    repeat (H) @(negedge clk); ps2_clk = 1'b0;
    repeat (SYNC-1) @(posedge clk);
    if (pin_lat) post_pin("stop_edge_latency_pre", 1'b0, 1'b0, 8'h00, ovf_exp, -1);
    if (pop_at_stop) begin
      @(negedge clk); nextdata_n = 1'b0;
    end
    @(posedge clk);
    if (pop_at_stop && q.size() != 0) void'(q.pop_front());
    ok = (f[0] == 1'b0) && (f[10] == 1'b1);
`ifdef PS2_KBD_RX_PARITY_CHECK_EN
    ok = ok && ((^f[9:1]) == 1'b1);
`endif
    if (!ok) err_exp++;
    else if (q.size() < DEPTH) q.push_back(code);
    else ovf_exp = 1'b1;
    if (pin_lat) post_pin("stop_edge_latency_post", 1'b1, 1'b1, code, ovf_exp, -1);
    @(negedge clk); nextdata_n = 1'b1;
    repeat (H) @(negedge clk); ps2_clk = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
  endtask

  task automatic pop_one();
    @(negedge clk); nextdata_n = 1'b0;
    @(posedge clk);
    if (q.size() != 0) void'(q.pop_front());
    @(negedge clk); nextdata_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); resetn = 1'b0;
    @(posedge clk);
    q.delete(); ovf_exp = 1'b0;
    @(negedge clk); resetn = 1'b1;
  endtask

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    pin("reset_state", 1'b0, 1'b1, 8'h00, 1'b0, 0);
    chk_en = 1'b1;

    // Pop while empty is ignored
    pop_one();
    pin("pop_when_empty", 1'b0, 1'b0, 8'h00, 1'b0, 0);

    // Single frame 0x1C with exact latency
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0);
    pop_one();
    pin("after_pop_1c", 1'b0, 1'b0, 8'h00, 1'b0, 0);

    // Two frames, ordering
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    pin("head_f0", 1'b1, 1'b1, 8'hF0, 1'b0, 0);
    pop_one();
    pin("head_1c", 1'b1, 1'b1, 8'h1C, 1'b0, 0);
    pop_one();
    pin("two_drained", 1'b0, 1'b0, 8'h00, 1'b0, 0);

    // Bad parity, then bad stop
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef PS2_KBD_RX_PARITY_CHECK_EN
    pin("bad_parity", 1'b0, 1'b0, 8'h00, 1'b0, 1);
`else
    pin("bad_parity", 1'b1, 1'b1, 8'h1C, 1'b0, 0);
`endif
    pop_one();
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PS2_KBD_RX_PARITY_CHECK_EN
    pin("bad_stop", 1'b0, 1'b0, 8'h00, 1'b0, 2);
`else
    pin("bad_stop", 1'b0, 1'b0, 8'h00, 1'b0, 1);
`endif

    // Overflow: 9 frames, no pops
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    pin("overflow_set", 1'b1, 1'b1, 8'h01, 1'b1, -1);
    for (int i = 0; i < 8; i++) pop_one();
    pin("overflow_drained", 1'b0, 1'b0, 8'h00, 1'b1, -1);

    // Full FIFO with pop coinciding with 9th stop edge
    do_reset();
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h09, 1'b0, 1'b1, 1'b0, 1'b1);
    pin("push_pop_full", 1'b1, 1'b1, 8'h02, 1'b0, -1);
    for (int i = 0; i < 8; i++) pop_one();
    pin("push_pop_drained", 1'b0, 1'b0, 8'h00, 1'b0, -1);

    // Timeout drops a partial frame silently
    send_partial(8'h2A, 5);
    repeat (TO + 1) @(negedge clk);
    send_frame(8'h2A, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PS2_KBD_RX_PARITY_CHECK_EN
    pin("after_timeout", 1'b1, 1'b1, 8'h2A, 1'b0, 2);
`else
    pin("after_timeout", 1'b1, 1'b1, 8'h2A, 1'b0, 1);
`endif
    pop_one();

    // Reset in the middle of a frame
    send_partial(8'h77, 7);
    do_reset();
    send_frame(8'h45, 1'b0, 1'b1, 1'b0, 1'b0);
    pin("after_mid_reset", 1'b1, 1'b1, 8'h45, 1'b0, -1);
    pop_one();
    pin("mid_reset_drained", 1'b0, 1'b0, 8'h00, 1'b0, -1);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
